// File: rtl/uart_rx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_pkg
//   Serial-link definitions shared by the UART receiver and transmitter:
//   FSM state encodings, the number of data bits per frame, and the default
//   bit period (100 MHz system clock, 9600 baud). Also provides the even
//   parity helper used when the parity bit is enabled.
// -----------------------------------------------------------------------------
package uart_rx_ctrl_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 10417;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Even parity: the transmitted parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchronizer for the asynchronous serial input. Both flops reset
//   to 1 so that the idle (high) line is never seen as a start edge coming
//   out of reset.
// Ports
//   CLK      in  system clock
//   RST_N    in  asynchronous reset, active-low
//   i_async  in  raw serial pin
//   o_sync   out synchronized serial line
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   8N1 UART receiver. Samples the synchronized line at mid-bit and hands each
//   byte to the consumer on a valid/ack handshake; reports framing errors and
//   overruns.
//
//   Handshake: rx_valid rises when a byte is committed and stays high, with
//   rx_data stable, until a cycle with rx_valid & rx_ack. A byte that completes
//   while rx_valid is high and not acknowledged in that same cycle is dropped
//   and overrun is set; overrun is cleared by the next ack.
//
//   Build option: define UART_RX_PARITY_EN to add an even-parity bit between
//   the data bits and the stop bit (11-bit frame). Without it parity_err is 0.
//
// Ports
//   CLK        in   system clock
//   RST_N      in   asynchronous reset, active-low
//   UART_RX    in   serial input, asynchronous, idle high
//   rx_data    out  received byte, stable while rx_valid=1
//   rx_valid   out  byte available, held until acknowledged
//   rx_ack     in   consumer takes rx_data when rx_valid & rx_ack
//   busy       out  receiver is not idle
//   frame_err  out  1-cycle pulse when the stop bit samples 0
//   overrun    out  sticky, byte dropped because previous was not taken
//   parity_err out  1-cycle pulse on parity mismatch
//   dbg_state  out  current FSM state encoding
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err,
    output logic [2:0]           dbg_state
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_MAX = TW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [TW-1:0] BIT_MAX  = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 r_rx_q;

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [TW-1:0]        r_timer;
    logic [TW-1:0]        w_timer_nxt;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;

    logic                 w_half;
    logic                 w_bit_done;
    logic                 w_commit;
    logic                 w_frame_err;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_overrun;
    logic                 r_frame_err;

`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad;
    logic                 w_par_bad_nxt;
    logic                 w_parity_err;
    logic                 r_parity_err;
`endif

    uart_rx_sync u_sync (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_async (UART_RX),
        .o_sync  (w_rx_s)
    );

    assign w_half     = (r_timer == HALF_MAX);
    assign w_bit_done = (r_timer == BIT_MAX);

    // State, timer, bit index and shift register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_q  <= 1'b1;
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_rx_q  <= w_rx_s;
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_commit    = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_parity_err  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = '0;
                // Only a high-to-low transition arms; a held-low line does not.
                if (r_rx_q && !w_rx_s) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_half) begin
                    w_timer_nxt = '0;
                    w_idx_nxt   = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_timer_nxt          = '0;
                    w_shift_nxt[r_idx]   = w_rx_s;
                    if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_timer_nxt   = '0;
                    w_par_bad_nxt = (w_rx_s != even_parity(r_shift));
                    w_state_nxt   = ST_STOP;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_done) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
                    w_frame_err = !w_rx_s;
`ifdef UART_RX_PARITY_EN
                    w_parity_err = r_par_bad;
                    w_commit     = w_rx_s && !r_par_bad;
`else
                    w_commit     = w_rx_s;
`endif
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Output register: byte hand-off, overrun and error pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= w_frame_err;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_parity_err;
`endif
            if (w_commit && (!r_valid || rx_ack)) begin
                // Slot is free (or being freed this cycle): take the new byte.
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (rx_ack) begin
                    r_overrun <= 1'b0;
                end
            end else if (w_commit) begin
                // Previous byte still pending: drop the new one.
                r_overrun <= 1'b1;
            end else if (rx_ack) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int CPB = 16;

    logic       CLK;
    logic       RST_N;
    logic       UART_RX;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int fe_total = 0;
    int pe_total = 0;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .UART_RX    (UART_RX),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Error-pulse monitor: counts high cycles, so a pulse wider than one
    // cycle shows up as a count above 1.
    always @(negedge CLK) begin
        if (RST_N) begin
            fe_total = fe_total + int'(frame_err);
            pe_total = pe_total + int'(parity_err);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        failures = failures + 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full frame, LSB first. With ack_commit the consumer asserts rx_ack
    // for exactly the cycle in which the stop bit is sampled (start edge + 2
    // sync + HALF_MAX + 1 + 9 bit periods, i.e. 10 cycles into the stop bit).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_ok, input logic ack_commit);
        UART_RX = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            repeat (CPB) tick();
        end
`ifdef UART_RX_PARITY_EN
        UART_RX = par_ok ? ^d : ~(^d);
        repeat (CPB) tick();
`else
        if (!par_ok) UART_RX = 1'b1;
`endif
        UART_RX = stop_bit;
        if (ack_commit) begin
            repeat (10) tick();
            rx_ack = 1'b1;
            tick();
            rx_ack = 1'b0;
            repeat (CPB - 11) tick();
        end else begin
            repeat (CPB) tick();
        end
        UART_RX = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ov;
        int         exp_fe;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int fe_base;
        int pe_base;
        int waited;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1};
        vecs[2] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 0};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 0};
        vecs[4] = '{8'h02, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0};
        vecs[6] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 0};
        vecs[7] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0};

        RST_N   = 1'b0;
        UART_RX = 1'b1;
        rx_ack  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        RST_N = 1'b1;
        repeat (4) tick();

        // Short low glitch: starts the receiver, then falls back to idle.
        fe_base = fe_total;
        UART_RX = 1'b0;
        repeat (5) tick();
        UART_RX = 1'b1;
        @(negedge CLK);
        check("glitch_busy", 32'(busy), 32'd1);
        waited = 0;
        while (busy && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        check("glitch_overrun", 32'(overrun), 32'd0);
        check("glitch_frame_err", 32'(fe_total - fe_base), 32'd0);
        tick();

        // Table-driven frames; state (pending byte, overrun) carries over.
        for (int v = 0; v < 8; v++) begin
            fe_base = fe_total;
            send_frame(vecs[v].data, vecs[v].stop, 1'b1, 1'b0);
            repeat (4) tick();
            @(negedge CLK);
            check($sformatf("vec%0d_valid", v), 32'(rx_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_ov));
            check($sformatf("vec%0d_frame_err", v), 32'(fe_total - fe_base), 32'(vecs[v].exp_fe));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
            if (vecs[v].ack) begin
                tick();
                ack_pulse();
                @(negedge CLK);
                check($sformatf("vec%0d_ack_valid", v), 32'(rx_valid), 32'd0);
                check($sformatf("vec%0d_ack_overrun", v), 32'(overrun), 32'd0);
                check($sformatf("vec%0d_ack_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
            end
            tick();
        end

        // Ack in the exact commit cycle: new byte replaces old, no overrun.
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        send_frame(8'h02, 1'b1, 1'b1, 1'b1);
        @(negedge CLK);
        check("ackcommit_valid", 32'(rx_valid), 32'd1);
        check("ackcommit_data", 32'(rx_data), 32'h02);
        check("ackcommit_overrun", 32'(overrun), 32'd0);
        tick();
        ack_pulse();
        @(negedge CLK);
        check("ackcommit_cleared", 32'(rx_valid), 32'd0);
        tick();

        // Line held low (break): one framing error, then no re-arm.
        fe_base = fe_total;
        UART_RX = 1'b0;
        repeat (13 * CPB) tick();
        @(negedge CLK);
        check("break_busy", 32'(busy), 32'd0);
        check("break_valid", 32'(rx_valid), 32'd0);
        check("break_frame_err", 32'(fe_total - fe_base), 32'd1);
        UART_RX = 1'b1;
        repeat (8) tick();

        // Reset in the middle of the data bits of 0xFF.
        UART_RX = 1'b0;
        repeat (CPB) tick();
        UART_RX = 1'b1;
        repeat (3 * CPB) tick();
        @(negedge CLK);
        check("midframe_busy", 32'(busy), 32'd1);
        RST_N = 1'b0;
        #1;
        @(negedge CLK);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(rx_valid), 32'd0);
        check("rst_mid_data", 32'(rx_data), 32'd0);
        check("rst_mid_overrun", 32'(overrun), 32'd0);
        check("rst_mid_frame_err", 32'(frame_err), 32'd0);
        check("rst_mid_parity_err", 32'(parity_err), 32'd0);
        tick();
        RST_N = 1'b1;
        repeat (6 * CPB) tick();
        @(negedge CLK);
        check("after_rst_valid", 32'(rx_valid), 32'd0);
        tick();
        fe_base = fe_total;
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        @(negedge CLK);
        check("post_rst_valid", 32'(rx_valid), 32'd1);
        check("post_rst_data", 32'(rx_data), 32'h5A);
        check("post_rst_frame_err", 32'(fe_total - fe_base), 32'd0);
        tick();
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        // Corrupted parity bit: parity_err pulse, byte not committed.
        repeat (4) tick();
        pe_base = pe_total;
        send_frame(8'h96, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        @(negedge CLK);
        check("parity_err_pulse", 32'(pe_total - pe_base), 32'd1);
        check("parity_valid", 32'(rx_valid), 32'd0);
        check("parity_data_kept", 32'(rx_data), 32'h5A);
`else
        pe_base = 0;
        @(negedge CLK);
        check("parity_err_tied", 32'(pe_total - pe_base), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
